rcv_sequencer: RTL and testbench

Control unit for the UART receive datapath: start-bit detector, 9-bit shift register, stop-bit checker and rx data buffer. It validates the start bit at mid-bit, generates mid-bit shift strobes at a parameterised bit period and sequences the stop-bit check. It then commits the frame to the buffer or drops it. It replaces the separate timer/rcu pairing with a single sequencer that adds false-start rejection and a receive-enable abort.

---
 rtl/rcv_pkg.sv | 17 +
 rtl/rcv_sequencer_if.sv | 45 ++++
 rtl/rcv_bit_timer.sv | 44 ++++
 rtl/rcv_sequencer.sv | 118 +++++++++++
 tb/tb_rcv_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rcv_pkg.sv
// Shared types and defaults for the UART receive sequencer.
// Imported by the interface, the bit timer and the sequencer top.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK,
        CHECK,
        LOAD
    } rcv_state_t;

    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/rcv_sequencer_if.sv
// Control bundle between the receive sequencer and the receive datapath.
// The master side is the sequencer; the slave side is the datapath.
interface rcv_sequencer_if;

    logic       rx_enable;
    logic       start_bit_detected;
    logic       serial_in;
    logic       framing_error;
    logic       shift_strobe;
    logic       sbc_clear;
    logic       sbc_enable;
    logic       load_buffer;
    logic       busy;
    logic       false_start;
    logic [3:0] bit_idx;

    modport master (
        input  rx_enable,
        input  start_bit_detected,
        input  serial_in,
        input  framing_error,
        output shift_strobe,
        output sbc_clear,
        output sbc_enable,
        output load_buffer,
        output busy,
        output false_start,
        output bit_idx
    );

    modport slave (
        output rx_enable,
        output start_bit_detected,
        output serial_in,
        output framing_error,
        input  shift_strobe,
        input  sbc_clear,
        input  sbc_enable,
        input  load_buffer,
        input  busy,
        input  false_start,
        input  bit_idx
    );

endinterface

// File: rtl/rcv_bit_timer.sv
// Clearable rollover counter used as the bit-period timer.
// Counts 0..rollover_val and wraps; clear has priority over counting.
module rcv_bit_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             count_enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] rollover_val,
    output logic [CNT_W-1:0] count_out,
    output logic             rollover_flag
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, explicit wrap at rollover_val, else increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rcv_sequencer.sv
// UART receive sequencer: start-bit validation, mid-bit shift strobes,
// stop-bit check sequencing and buffer commit, with enable abort.
module rcv_sequencer
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CNT_W        = 4
) (
    input logic         clk,
    input logic         n_rst,
    rcv_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_IDX  = 4'(DATA_BITS);

    rcv_state_t       state_q;
    rcv_state_t       state_d;
    logic [3:0]       bit_idx_q;
    logic [3:0]       bit_idx_d;
    logic             false_start_q;
    logic             false_start_d;
    logic [CNT_W-1:0] cnt;
    logic             roll;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] roll_val;

    // Timer runs only while timing a bit; idle or abort forces it to zero.
    always_comb begin
        cnt_en   = (state_q == START_CHK) || (state_q == RECV);
        cnt_clr  = (state_q == IDLE) || !bus.rx_enable;
        roll_val = (state_q == START_CHK) ? HALF_LAST : FULL_LAST;
    end

    rcv_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .count_enable (cnt_en),
        .clear        (cnt_clr),
        .rollover_val (roll_val),
        .count_out    (cnt),
        .rollover_flag(roll)
    );

    // Next-state, bit index and false-start flag; abort overrides all.
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        false_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_enable && bus.start_bit_detected) begin
                    state_d   = START_CHK;
                    bit_idx_d = '0;
                end
            end
            START_CHK: begin
                if (roll) begin
                    if (bus.serial_in) begin
                        state_d       = IDLE;
                        false_start_d = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (roll) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP_CHK;
                    end
                end
            end
            STOP_CHK: state_d = CHECK;
            CHECK: begin
                state_d = bus.framing_error ? IDLE : LOAD;
            end
            LOAD:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (!bus.rx_enable && (state_q != IDLE)) begin
            state_d       = IDLE;
            bit_idx_d     = '0;
            false_start_d = 1'b0;
        end
    end

    // State, bit index and false-start registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            false_start_q <= false_start_d;
        end
    end

    // Moore outputs decoded from registered state and counter.
    always_comb begin
        bus.shift_strobe = (state_q == RECV) && (cnt == FULL_LAST);
        bus.sbc_clear    = (state_q == START_CHK);
        bus.sbc_enable   = (state_q == STOP_CHK);
        bus.load_buffer  = (state_q == LOAD);
        bus.busy         = (state_q != IDLE);
        bus.false_start  = false_start_q;
        bus.bit_idx      = bit_idx_q;
    end

endmodule

// File: tb/tb_rcv_sequencer.sv
// Scoreboard bench for rcv_sequencer: a line/start driver plays planned
// frames, a monitor pops expected output pulses and compares them.
module tb_rcv_sequencer;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    rcv_sequencer_if bus ();

    rcv_sequencer #(
        .CLKS_PER_BIT(10),
        .DATA_BITS   (8),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.master)
    );

    typedef struct {
        int c;
        int k;
        int v;
    } ev_t;

    ev_t  exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   line_a[int];
    bit   sbd_a[int];
    bit   off_a[int];
    logic fe;
    logic [8:0] sr;

    assign bus.framing_error = fe;

    // Cycle n is the interval that ends at posedge n.
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-ins: stop-bit checker and 9-bit shift register.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe <= 1'b0;
            sr <= '0;
        end else begin
            if (bus.sbc_clear) fe <= 1'b0;
            else if (bus.sbc_enable) fe <= ~bus.serial_in;
            if (bus.shift_strobe) sr <= {bus.serial_in, sr[8:1]};
        end
    end

    function automatic string kname(int k);
        case (k)
            0: return "shift_strobe";
            1: return "sbc_enable";
            2: return "load_buffer";
            3: return "false_start";
            default: return "unknown";
        endcase
    endfunction

    function automatic int outs();
        return int'({bus.shift_strobe, bus.sbc_clear, bus.sbc_enable,
                     bus.load_buffer, bus.busy, bus.false_start,
                     bus.bit_idx});
    endfunction

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, required %0d",
                     name, cyc + 1, act, req);
        end
    endtask

    task automatic mon_ev(int k, int v);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s @cycle %0d val %0d",
                     kname(k), cyc + 1, v);
        end else begin
            e = exp_q.pop_front();
            if (e.c != cyc + 1 || e.k != k || e.v != v) begin
                miscompares++;
                $display("FAIL event: got %s val %0d @cycle %0d, required %s val %0d @cycle %0d",
                         kname(k), v, cyc + 1, kname(e.k), e.v, e.c);
            end
        end
    endtask

    task automatic push(int c, int k, int v);
        ev_t e;
        e.c = c;
        e.k = k;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic push_strobes(int t, int n);
        for (int k = 1; k <= n; k++) push(t + 5 + 10 * k, 0, k - 1);
    endtask

    task automatic plan_frame(int t, logic [7:0] d, bit stop);
        for (int c = t; c < t + 10; c++) line_a[c] = 1'b0;
        for (int j = 0; j < 8; j++)
            for (int c = t + 10 * (j + 1); c < t + 10 * (j + 2); c++)
                line_a[c] = d[j];
        for (int c = t + 90; c < t + 100; c++) line_a[c] = stop;
        sbd_a[t] = 1'b1;
    endtask

    task automatic wait_until(int c);
        while (cyc + 1 < c) @(negedge clk);
    endtask

    // Input driver: applies planned values for the cycle now starting.
    initial begin
        forever begin
            @(negedge clk);
            bus.serial_in = line_a.exists(cyc + 1) ? line_a[cyc + 1] : 1'b1;
            bus.start_bit_detected = sbd_a.exists(cyc + 1);
            bus.rx_enable = !off_a.exists(cyc + 1);
        end
    end

    // Monitor: every output pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1) begin
                if (bus.shift_strobe) mon_ev(0, int'(bus.bit_idx));
                if (bus.sbc_enable) mon_ev(1, 0);
                if (bus.load_buffer) mon_ev(2, int'(sr[7:0]));
                if (bus.false_start) mon_ev(3, 0);
            end
        end
    end

    initial begin
        int t1, t2, t3, t4, t5, t6;
        bus.rx_enable          = 1'b1;
        bus.start_bit_detected = 1'b0;
        bus.serial_in          = 1'b1;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #1 chk("reset_outputs", outs(), 0);
        wait_until(5);
        n_rst = 1'b1;

        t1 = 20;
        t2 = t1 + 99;
        plan_frame(t1, 8'hA5, 1'b1);
        sbd_a[t1 + 50] = 1'b1;
        push_strobes(t1, 9);
        push(t1 + 96, 1, 0);
        push(t1 + 98, 2, 'hA5);
        plan_frame(t2, 8'h3C, 1'b0);
        push_strobes(t2, 9);
        push(t2 + 96, 1, 0);

        wait_until(t1);
        chk("idle_busy", int'(bus.busy), 0);
        wait_until(t1 + 1);
        chk("start_chk_busy", int'(bus.busy), 1);
        chk("start_chk_sbc_clear", int'(bus.sbc_clear), 1);
        wait_until(t1 + 97);
        chk("bit_idx_hold", int'(bus.bit_idx), 9);
        wait_until(t1 + 99);
        chk("frame1_done_busy", int'(bus.busy), 0);
        wait_until(t1 + 100);
        chk("b2b_accept_busy", int'(bus.busy), 1);
        chk("b2b_bit_idx_clear", int'(bus.bit_idx), 0);
        wait_until(t2 + 97);
        chk("bad_stop_check_busy", int'(bus.busy), 1);
        wait_until(t2 + 98);
        chk("bad_stop_idle", int'(bus.busy), 0);

        t3 = 230;
        sbd_a[t3] = 1'b1;
        for (int c = t3; c < t3 + 3; c++) line_a[c] = 1'b0;
        push(t3 + 6, 3, 0);
        wait_until(t3 + 5);
        chk("glitch_busy_t5", int'(bus.busy), 1);
        wait_until(t3 + 6);
        chk("glitch_busy_t6", int'(bus.busy), 0);

        t4 = 260;
        plan_frame(t4, 8'h5A, 1'b1);
        off_a[t4 + 40] = 1'b1;
        push_strobes(t4, 3);
        wait_until(t4 + 40);
        chk("abort_busy_t40", int'(bus.busy), 1);
        wait_until(t4 + 41);
        chk("abort_busy_t41", int'(bus.busy), 0);
        chk("abort_bit_idx", int'(bus.bit_idx), 0);

        t5 = 400;
        plan_frame(t5, 8'hFF, 1'b1);
        push_strobes(t5, 5);
        wait_until(t5 + 60);
        n_rst = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        wait_until(t5 + 63);
        n_rst = 1'b1;

        t6 = 520;
        plan_frame(t6, 8'h81, 1'b1);
        push_strobes(t6, 9);
        push(t6 + 96, 1, 0);
        push(t6 + 98, 2, 'h81);
        wait_until(t6 + 98);
        chk("recover_load_busy", int'(bus.busy), 1);
        wait_until(t6 + 99);
        chk("recover_idle_busy", int'(bus.busy), 0);

        wait_until(t6 + 110);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
